// File: rtl/pid_pkg.sv
// Shared widths, gains and the signed clamp helper for the pid_steer heading-hold controller.
package pid_pkg;

    localparam int P_COEFF   = 3;
    localparam int D_COEFF   = 14;
    localparam int ERR_W     = 10;
    localparam int DDIFF_W   = 7;
    localparam int INT_W     = 16;
    localparam int SPD_W     = 11;

    localparam int HDNG_W    = 12;
    localparam int FRWRD_W   = 10;
    localparam int ERR_RAW_W = HDNG_W + 1;
    localparam int DRAW_W    = ERR_W + 1;
    localparam int PTERM_W   = 14;
    localparam int DTERM_W   = 13;
    localparam int ITERM_W   = 12;
    localparam int IFAST_W   = INT_W - 3;
    localparam int PID_W     = 15;
    localparam int PIDS_W    = PID_W - 3;
    localparam int SUM_W     = SPD_W + 2;

    // Clamp a sign-extended value to the range of a signed field of the given width.
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] i_val,
                                                     input int i_width);
        logic signed [31:0] w_hi;
        logic signed [31:0] w_lo;
        w_hi = (32'sd1 <<< (i_width - 1)) - 32'sd1;
        w_lo = -(32'sd1 <<< (i_width - 1));
        if (i_val > w_hi) return w_hi;
        if (i_val < w_lo) return w_lo;
        return i_val;
    endfunction

endpackage

// File: rtl/pid_steer_if.sv
// Sample-in / speed-out bundle between the heading integrator, pid_steer and the motor drive.
interface pid_steer_if;
    import pid_pkg::*;

    logic                      hdng_vld;
    logic signed [HDNG_W-1:0]  heading;
    logic signed [HDNG_W-1:0]  dsrd_hdng;
    logic                      moving;
    logic        [FRWRD_W-1:0] frwrd;
    logic signed [SPD_W-1:0]   lft_spd;
    logic signed [SPD_W-1:0]   rght_spd;
    logic                      spd_vld;

    modport master (output hdng_vld, heading, dsrd_hdng, moving, frwrd,
                    input  lft_spd, rght_spd, spd_vld);
    modport slave  (input  hdng_vld, heading, dsrd_hdng, moving, frwrd,
                    output lft_spd, rght_spd, spd_vld);

endinterface

// File: rtl/sat_signed.sv
// Combinational signed clamp from an IN_W-bit value into the OUT_W-bit range.
module sat_signed
    import pid_pkg::*;
#(
    parameter int IN_W  = 13,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val
);

    assign o_val = OUT_W'(sat_clamp(32'(i_val), OUT_W));

endmodule

// File: rtl/pid_steer.sv
// Heading-hold PID: saturated error (A), P/D terms and integrator (B), wheel speeds (C).
module pid_steer
    import pid_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input logic        clk,
    input logic        rst,
    pid_steer_if.slave bus
);

    logic signed [ERR_RAW_W-1:0] w_err;
    logic signed [ERR_W-1:0]     w_err_sat;
    logic signed [DRAW_W-1:0]    w_ddiff_raw;
    logic signed [DDIFF_W-1:0]   w_ddiff;
    logic signed [INT_W-1:0]     w_int_sum;
    logic                        w_int_ovf;
    logic signed [ITERM_W-1:0]   w_i_term;
    logic signed [PID_W-1:0]     w_pid;
    logic signed [PIDS_W-1:0]    w_pid_s;
    logic signed [SUM_W-1:0]     w_lft_raw;
    logic signed [SUM_W-1:0]     w_rght_raw;
    logic signed [SPD_W-1:0]     w_lft_sat;
    logic signed [SPD_W-1:0]     w_rght_sat;

    logic signed [ERR_W-1:0]     r_err_ff;
    logic signed [ERR_W-1:0]     r_prev_err;
    logic signed [PTERM_W-1:0]   r_p_term;
    logic signed [DTERM_W-1:0]   r_d_term;
    logic signed [INT_W-1:0]     r_integrator;
    logic signed [SPD_W-1:0]     r_lft_spd;
    logic signed [SPD_W-1:0]     r_rght_spd;
    logic                        r_vld_a;
    logic                        r_vld_b;
    logic                        r_spd_vld;

    assign w_err = ERR_RAW_W'(bus.heading) - ERR_RAW_W'(bus.dsrd_hdng);
    sat_signed #(.IN_W(ERR_RAW_W), .OUT_W(ERR_W)) u_sat_err (.i_val(w_err), .o_val(w_err_sat));

    assign w_ddiff_raw = DRAW_W'(r_err_ff) - DRAW_W'(r_prev_err);
    sat_signed #(.IN_W(DRAW_W), .OUT_W(DDIFF_W)) u_sat_ddiff (.i_val(w_ddiff_raw), .o_val(w_ddiff));

    // Same-sign operands whose sum flips sign mean a wrap; the integrator then holds.
    assign w_int_sum = r_integrator + INT_W'(r_err_ff);
    assign w_int_ovf = (r_integrator[INT_W-1] == r_err_ff[ERR_W-1]) &&
                       (w_int_sum[INT_W-1] != r_integrator[INT_W-1]);

    if (FAST_SIM) begin : g_iterm_fast
        logic signed [IFAST_W-1:0] w_i_wide;
        assign w_i_wide = IFAST_W'(r_integrator >>> 3);
        sat_signed #(.IN_W(IFAST_W), .OUT_W(ITERM_W)) u_sat_iterm (.i_val(w_i_wide), .o_val(w_i_term));
    end else begin : g_iterm_real
        assign w_i_term = ITERM_W'(r_integrator >>> 4);
    end

    assign w_pid      = PID_W'(r_p_term) + PID_W'(w_i_term) + PID_W'(r_d_term);
    assign w_pid_s    = PIDS_W'(w_pid >>> 3);
    assign w_lft_raw  = SUM_W'($signed({1'b0, bus.frwrd})) - SUM_W'(w_pid_s);
    assign w_rght_raw = SUM_W'($signed({1'b0, bus.frwrd})) + SUM_W'(w_pid_s);

    sat_signed #(.IN_W(SUM_W), .OUT_W(SPD_W)) u_sat_lft  (.i_val(w_lft_raw),  .o_val(w_lft_sat));
    sat_signed #(.IN_W(SUM_W), .OUT_W(SPD_W)) u_sat_rght (.i_val(w_rght_raw), .o_val(w_rght_sat));

    // NOTE: every register here uses <= so each stage reads the previous stage's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_ff     <= '0;
            r_prev_err   <= '0;
            r_p_term     <= '0;
            r_d_term     <= '0;
            r_integrator <= '0;
            r_lft_spd    <= '0;
            r_rght_spd   <= '0;
            r_vld_a      <= 1'b0;
            r_vld_b      <= 1'b0;
            r_spd_vld    <= 1'b0;
        end else begin
            r_vld_a   <= bus.hdng_vld;
            r_vld_b   <= r_vld_a;
            r_spd_vld <= r_vld_b;

            if (bus.hdng_vld) r_err_ff <= w_err_sat;

            if (r_vld_a) begin
                r_p_term   <= PTERM_W'(r_err_ff) * PTERM_W'(P_COEFF);
                r_d_term   <= DTERM_W'(w_ddiff) * DTERM_W'(D_COEFF);
                r_prev_err <= r_err_ff;
            end

            if (!bus.moving)                r_integrator <= '0;
            else if (r_vld_a && !w_int_ovf) r_integrator <= w_int_sum;

            if (r_vld_b) begin
                r_lft_spd  <= bus.moving ? w_lft_sat  : '0;
                r_rght_spd <= bus.moving ? w_rght_sat : '0;
            end
        end
    end

    assign bus.lft_spd  = r_lft_spd;
    assign bus.rght_spd = r_rght_spd;
    assign bus.spd_vld  = r_spd_vld;

endmodule
